// File: rtl/mem_loader.sv
// Download-stream copy engine: packs host bytes into 16-bit words and writes them through mem_copy; also does single-word readback.
// Word reaches the strobe 3 cycles after its 2nd byte; 7 cycles per write; a word completing into a full FIFO is dropped and flagged sticky.
module mem_loader #(
  parameter int WE_CYCLES  = 4,
  parameter int GAP_CYCLES = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_ram,
  input  logic        reset_n,
  input  logic        dl_start,
  input  logic [24:0] dl_base,
  input  logic        dl_virt,
  input  logic        dl_wr,
  input  logic [7:0]  dl_data,
  input  logic        dl_end,
  input  logic        rd_req,
  input  logic [24:0] rd_addr,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        dl_busy,
  output logic        dl_overflow,
  output logic        mem_copy,
  output logic        mem_copy_virt,
  output logic [24:0] mem_copy_addr,
  output logic [15:0] mem_copy_data_i,
  input  logic [15:0] mem_copy_data_o,
  output logic        mem_copy_we,
  output logic        mem_copy_rd
);

  localparam int CNT_MAX = (WE_CYCLES > GAP_CYCLES) ? WE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW      = 25 + 16;

  typedef enum logic [2:0] {
    S_IDLE, S_SESS, S_SETUP, S_WRITE, S_GAP, S_RSETUP, S_READ
  } state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_we_last, w_gap_last;
  logic               w_start, w_rd_go, w_in_sess, w_accept;

  logic               r_virt, r_end_pend, r_half_vld, r_ovf;
  logic [7:0]         r_half;
  logic [24:0]        r_wr_addr;
  logic [24:0]        r_addr;
  logic [15:0]        r_data;
  logic [15:0]        r_rd_data;
  logic               r_rd_valid;

  logic               w_byte, w_end;
  logic               w_word_vld;
  logic [15:0]        w_word_dat;
  logic               w_half_vld_nxt;
  logic [7:0]         w_half_nxt;

  logic [FW-1:0]      r_fifo_mem [FIFO_DEPTH];
  logic [AW:0]        r_wp, r_rp;
  logic               w_fifo_empty, w_fifo_full, w_push, w_pop, w_drop;
  logic [FW-1:0]      w_head;

  logic               w_mem_copy, w_we, w_rd, w_virt_out;

  assign w_we_last  = (r_cnt == CNT_W'(WE_CYCLES - 1));
  assign w_gap_last = (r_cnt == CNT_W'(GAP_CYCLES - 1));
  assign w_start    = (r_state == S_IDLE) && dl_start;
  assign w_rd_go    = (r_state == S_IDLE) && rd_req && !dl_start;
  assign w_in_sess  = (r_state == S_SESS) || (r_state == S_SETUP) ||
                      (r_state == S_WRITE) || (r_state == S_GAP);
  assign w_accept   = w_in_sess && !r_end_pend;
  assign w_byte     = w_accept && dl_wr;
  assign w_end      = w_accept && dl_end;

  // Packed-word FIFO; each entry carries its own destination address so dropped words keep later addresses correct.
  assign w_fifo_empty = (r_wp == r_rp);
  assign w_fifo_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_push       = w_word_vld && !w_fifo_full;
  assign w_drop       = w_word_vld && w_fifo_full;
  assign w_pop        = (r_state == S_WRITE) && w_we_last && !w_fifo_empty;
  assign w_head       = r_fifo_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk_ram or negedge reset_n) begin
    if (!reset_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  always_ff @(posedge clk_ram) begin
    if (w_push) r_fifo_mem[r_wp[AW-1:0]] <= {r_wr_addr, w_word_dat};
  end

  // Byte packer: a byte arriving together with dl_end is taken before the flush.
  always_comb begin
    w_word_vld     = 1'b0;
    w_word_dat     = {dl_data, r_half};
    w_half_vld_nxt = r_half_vld;
    w_half_nxt     = r_half;
    if (w_byte) begin
      if (r_half_vld) begin
        w_word_vld     = 1'b1;
        w_word_dat     = {dl_data, r_half};
        w_half_vld_nxt = 1'b0;
      end else if (w_end) begin
        w_word_vld     = 1'b1;
        w_word_dat     = {8'h00, dl_data};
        w_half_vld_nxt = 1'b0;
      end else begin
        w_half_vld_nxt = 1'b1;
        w_half_nxt     = dl_data;
      end
    end else if (w_end && r_half_vld) begin
      w_word_vld     = 1'b1;
      w_word_dat     = {8'h00, r_half};
      w_half_vld_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_ram or negedge reset_n) begin
    if (!reset_n) begin
      r_virt     <= 1'b0;
      r_end_pend <= 1'b0;
      r_half_vld <= 1'b0;
      r_half     <= '0;
      r_ovf      <= 1'b0;
      r_wr_addr  <= '0;
    end else if (w_start) begin
      r_virt     <= dl_virt;
      r_end_pend <= 1'b0;
      r_half_vld <= 1'b0;
      r_half     <= '0;
      r_ovf      <= 1'b0;
      r_wr_addr  <= dl_base & ~25'd1;
    end else begin
      r_half_vld <= w_half_vld_nxt;
      r_half     <= w_half_nxt;
      if (w_end)      r_end_pend <= 1'b1;
      if (w_drop)     r_ovf      <= 1'b1;
      if (w_word_vld) r_wr_addr  <= r_wr_addr + 25'd2;
    end
  end

  always_ff @(posedge clk_ram or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
    end
  end

  // The last GAP cycle goes straight to SETUP when a word is waiting, giving 1+WE+GAP cycles per word.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (dl_start)    w_next = S_SESS;
        else if (rd_req) w_next = S_RSETUP;
      end
      S_SESS: begin
        if (!w_fifo_empty)                  w_next = S_SETUP;
        else if (r_end_pend && !r_half_vld) w_next = S_IDLE;
      end
      S_SETUP:  w_next = S_WRITE;
      S_WRITE:  if (w_we_last) w_next = S_GAP;
      S_GAP: begin
        if (w_gap_last) begin
          if (!w_fifo_empty)                  w_next = S_SETUP;
          else if (r_end_pend && !r_half_vld) w_next = S_IDLE;
          else                                w_next = S_SESS;
        end
      end
      S_RSETUP: w_next = S_READ;
      S_READ:   if (w_we_last) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_mem_copy = (r_state != S_IDLE);
    w_we       = (r_state == S_WRITE);
    w_rd       = (r_state == S_READ);
    w_virt_out = r_virt && w_in_sess;
  end

  // Address/data are loaded on entry to SETUP/RSETUP and held through the strobe.
  always_ff @(posedge clk_ram or negedge reset_n) begin
    if (!reset_n) begin
      r_addr     <= '0;
      r_data     <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_next == S_SETUP && r_state != S_SETUP) begin
        r_addr <= w_head[FW-1:16];
        r_data <= w_head[15:0];
      end else if (w_rd_go) begin
        r_addr <= rd_addr & ~25'd1;
      end
      r_rd_valid <= (r_state == S_READ) && w_we_last;
      if ((r_state == S_READ) && w_we_last) r_rd_data <= mem_copy_data_o;
    end
  end

  assign mem_copy        = w_mem_copy;
  assign dl_busy         = w_mem_copy;
  assign mem_copy_we     = w_we;
  assign mem_copy_rd     = w_rd;
  assign mem_copy_virt   = w_virt_out;
  assign mem_copy_addr   = r_addr;
  assign mem_copy_data_i = r_data;
  assign rd_data         = r_rd_data;
  assign rd_valid        = r_rd_valid;
  assign dl_overflow     = r_ovf;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: write sessions, flush, overflow, wrap, readback, async reset.
module tb_mem_loader;

  logic        clk_ram = 1'b0;
  logic        reset_n = 1'b0;
  logic        dl_start = 1'b0;
  logic [24:0] dl_base = '0;
  logic        dl_virt = 1'b0;
  logic        dl_wr = 1'b0;
  logic [7:0]  dl_data = '0;
  logic        dl_end = 1'b0;
  logic        rd_req = 1'b0;
  logic [24:0] rd_addr = '0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        dl_busy;
  logic        dl_overflow;
  logic        mem_copy;
  logic        mem_copy_virt;
  logic [24:0] mem_copy_addr;
  logic [15:0] mem_copy_data_i;
  logic [15:0] mem_copy_data_o = '0;
  logic        mem_copy_we;
  logic        mem_copy_rd;

  int errors = 0;
  int checks = 0;

  mem_loader dut (
    .clk_ram(clk_ram), .reset_n(reset_n),
    .dl_start(dl_start), .dl_base(dl_base), .dl_virt(dl_virt),
    .dl_wr(dl_wr), .dl_data(dl_data), .dl_end(dl_end),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .dl_busy(dl_busy), .dl_overflow(dl_overflow),
    .mem_copy(mem_copy), .mem_copy_virt(mem_copy_virt), .mem_copy_addr(mem_copy_addr),
    .mem_copy_data_i(mem_copy_data_i), .mem_copy_data_o(mem_copy_data_o),
    .mem_copy_we(mem_copy_we), .mem_copy_rd(mem_copy_rd)
  );

  always #5 clk_ram = ~clk_ram;

  // Memory-side monitor: logs each write strobe with its address, data, virt flag and width.
  logic [24:0] wr_addr[$];
  logic [15:0] wr_data[$];
  logic        wr_virt[$];
  int          wr_len[$];
  int          cur_len = 0;
  logic        prev_we = 1'b0;
  int          rd_cnt = 0;
  int          unstable = 0;
  int          both_hi = 0;

  always @(negedge clk_ram) begin
    if (mem_copy_we) begin
      if (!prev_we) begin
        wr_addr.push_back(mem_copy_addr);
        wr_data.push_back(mem_copy_data_i);
        wr_virt.push_back(mem_copy_virt);
        cur_len = 1;
      end else begin
        cur_len++;
        if (mem_copy_addr !== wr_addr[$] || mem_copy_data_i !== wr_data[$]) unstable++;
      end
    end else if (prev_we) begin
      wr_len.push_back(cur_len);
    end
    if (rd_valid) rd_cnt++;
    if (mem_copy_we && mem_copy_rd) both_hi++;
    prev_we = mem_copy_we;
  end

  task automatic tick();
    @(posedge clk_ram);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_log();
    wr_addr.delete();
    wr_data.delete();
    wr_virt.delete();
    wr_len.delete();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (mem_copy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, mem_copy}, 32'd0);
  endtask

  task automatic chk_wr(input string tag, input int i, input logic [24:0] a, input logic [15:0] d);
    chk({tag, "_addr"}, (i < wr_addr.size()) ? {7'd0, wr_addr[i]} : 32'hDEAD_BEEF, {7'd0, a});
    chk({tag, "_data"}, (i < wr_data.size()) ? {16'd0, wr_data[i]} : 32'hDEAD_BEEF, {16'd0, d});
    chk({tag, "_len"}, (i < wr_len.size()) ? wr_len[i] : -1, 32'd4);
  endtask

  task automatic start_sess(input logic [24:0] base, input logic virt);
    dl_start = 1'b1;
    dl_base  = base;
    dl_virt  = virt;
    tick();
    dl_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    dl_wr   = 1'b1;
    dl_data = b;
    tick();
    dl_wr   = 1'b0;
  endtask

  task automatic end_sess();
    dl_end = 1'b1;
    tick();
    dl_end = 1'b0;
  endtask

  initial begin
    int keep[6];
    int rd_before;
    keep = '{0, 1, 2, 3, 4, 7};

    // Reset state
    tick(); tick(); tick();
    chk("rst_mem_copy", {31'd0, mem_copy}, 32'd0);
    chk("rst_busy", {31'd0, dl_busy}, 32'd0);
    chk("rst_we_rd", {30'd0, mem_copy_we, mem_copy_rd}, 32'd0);
    chk("rst_addr", {7'd0, mem_copy_addr}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_ovf", {31'd0, dl_overflow}, 32'd0);
    chk("post_rst_idle", {31'd0, mem_copy}, 32'd0);

    // Four-byte write with odd base
    clr_log();
    start_sess(25'h00E0001, 1'b0);
    chk("sess_mem_copy", {31'd0, mem_copy}, 32'd1);
    chk("sess_busy", {31'd0, dl_busy}, 32'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    chk("setup_we_low", {31'd0, mem_copy_we}, 32'd0);
    chk("setup_addr", {7'd0, mem_copy_addr}, 32'h00E0000);
    chk("setup_data", {16'd0, mem_copy_data_i}, 32'h2211);
    send_byte(8'h44);
    chk("we_rise", {31'd0, mem_copy_we}, 32'd1);
    end_sess();
    wait_idle("four_idle", 100);
    chk("four_count", wr_addr.size(), 32'd2);
    chk_wr("four_w0", 0, 25'h00E0000, 16'h2211);
    chk_wr("four_w1", 1, 25'h00E0002, 16'h4433);

    // Odd-length flush with dl_end alongside the last byte
    clr_log();
    start_sess(25'h0000200, 1'b0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    dl_end = 1'b1;
    send_byte(8'hCC);
    dl_end = 1'b0;
    wait_idle("odd_idle", 100);
    chk("odd_count", wr_addr.size(), 32'd2);
    chk_wr("odd_w0", 0, 25'h0000200, 16'hBBAA);
    chk_wr("odd_w1", 1, 25'h0000202, 16'h00CC);

    // Overflow: a byte every cycle; words 5 and 6 find the FIFO full
    clr_log();
    start_sess(25'h0001000, 1'b0);
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    end_sess();
    wait_idle("ovf_idle", 300);
    chk("ovf_flag", {31'd0, dl_overflow}, 32'd1);
    chk("ovf_count", wr_addr.size(), 32'd6);
    for (int j = 0; j < 6; j++)
      chk_wr("ovf_w", j, 25'h0001000 + 25'(2 * keep[j]),
             {8'(2 * keep[j] + 1), 8'(2 * keep[j])});

    // Address wrap, virtual session; new dl_start clears overflow
    clr_log();
    start_sess(25'h1FFFFFE, 1'b1);
    chk("ovf_cleared", {31'd0, dl_overflow}, 32'd0);
    chk("virt_sess", {31'd0, mem_copy_virt}, 32'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    end_sess();
    wait_idle("wrap_idle", 100);
    chk("wrap_count", wr_addr.size(), 32'd2);
    chk_wr("wrap_w0", 0, 25'h1FFFFFE, 16'h0201);
    chk_wr("wrap_w1", 1, 25'h0000000, 16'h0403);
    chk("wrap_virt", (wr_virt.size() > 0) ? {31'd0, wr_virt[0]} : 32'd9, 32'd1);

    // Readback
    mem_copy_data_o = 16'h1234;
    rd_before = rd_cnt;
    rd_req  = 1'b1;
    rd_addr = 25'h0000101;
    tick();
    rd_req = 1'b0;
    chk("rd_mem_copy", {31'd0, mem_copy}, 32'd1);
    chk("rd_setup_low", {31'd0, mem_copy_rd}, 32'd0);
    chk("rd_addr", {7'd0, mem_copy_addr}, 32'h0000100);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("rd_strobe", {31'd0, mem_copy_rd}, (k <= 4) ? 32'd1 : 32'd0);
      chk("rd_virt", {31'd0, mem_copy_virt}, 32'd0);
      chk("rd_valid_t", {31'd0, rd_valid}, (k == 5) ? 32'd1 : 32'd0);
    end
    chk("rd_data", {16'd0, rd_data}, 32'h1234);
    chk("rd_release", {31'd0, mem_copy}, 32'd0);
    tick();
    chk("rd_valid_pulse", {31'd0, rd_valid}, 32'd0);
    chk("rd_pulses", rd_cnt - rd_before, 32'd1);

    // dl_start beats a simultaneous rd_req; rd_req inside a session is ignored
    clr_log();
    rd_before = rd_cnt;
    rd_req = 1'b1;
    start_sess(25'h0000300, 1'b0);
    chk("start_wins", {31'd0, mem_copy_rd}, 32'd0);
    tick();
    rd_req = 1'b0;
    end_sess();
    wait_idle("rdsess_idle", 100);
    tick(); tick(); tick(); tick(); tick(); tick(); tick(); tick();
    chk("rd_in_sess_none", rd_cnt - rd_before, 32'd0);
    chk("rdsess_writes", wr_addr.size(), 32'd0);

    // Asynchronous reset during WRITE
    start_sess(25'h0000400, 1'b0);
    send_byte(8'h55);
    send_byte(8'h66);
    begin
      int n = 0;
      while (mem_copy_we !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
    end
    chk("rst_we_seen", {31'd0, mem_copy_we}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_mem_copy", {31'd0, mem_copy}, 32'd0);
    chk("arst_we", {31'd0, mem_copy_we}, 32'd0);
    chk("arst_busy", {31'd0, dl_busy}, 32'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick();
    chk("arst_idle", {31'd0, mem_copy}, 32'd0);
    clr_log();
    start_sess(25'h0000500, 1'b0);
    end_sess();
    wait_idle("arst_empty_idle", 50);
    chk("arst_fifo_empty", wr_addr.size(), 32'd0);

    chk("strobe_stable", unstable, 32'd0);
    chk("strobe_exclusive", both_hi, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
